hc161_seq_ctrl: RTL and testbench

- Sequencer for one 4-bit synchronous presettable counter stage with active-low clear (MR), active-low parallel load (PE), count enables (CEP, CET), data D and output Q.
- Loads a programmed preset, then runs the counter for a programmed number of terminal-count periods, with either auto-reload or free wrap.
- Supports pause and abort, and reports per-period ticks and completion.
- Sits between the control/register logic and the counter instance.

---
 rtl/hc161_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hc161_seq_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc161_seq_ctrl.sv
// Sequencer for a single 74HC161-style 4-bit counter stage.
// Loads a preset, then runs the counter for a programmed number of
// terminal-count periods, using either auto-reload or free wrap.
// It supports pause (HOLD) and abort, and reports a tick per period
// and a completion pulse.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | counter parked, waiting for START
// LOAD  | one cycle, parallel-loads the preset into the counter
// RUN   | counting, detects terminal count, reloads or wraps
// FIN   | one cycle, DONE and final TICK visible, counter stopped
// CLR   | one cycle, clears the counter after an abort
module hc161_seq_ctrl #(
  parameter int W_REP = 8
) (
  input  logic             CP,
  input  logic             MR,
  input  logic             START,
  input  logic             ABORT,
  input  logic             HOLD,
  input  logic             MODE,
  input  logic [3:0]       LOAD_VAL,
  input  logic [W_REP-1:0] REPEAT,
  input  logic [3:0]       Q_IN,
  output logic             CNT_MR_N,
  output logic             CNT_PE_N,
  output logic             CNT_CEP,
  output logic             CNT_CET,
  output logic [3:0]       CNT_D,
  output logic             BUSY,
  output logic             TICK,
  output logic             DONE,
  output logic [W_REP-1:0] PERIOD
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_FIN  = 3'd3,
    S_CLR  = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // Configuration captured at START so that input changes mid-run are harmless.
  logic [3:0]       cfg_load;
  logic [W_REP-1:0] cfg_rep;
  logic             cfg_mode;

  logic             term;
  logic             last_period;
  logic             term_ok;
  logic [W_REP-1:0] period_inc;

  // Terminal event: the counter rolls on this edge. HOLD masks it even at Q=F.
  assign term        = (state == S_RUN) && !HOLD && (Q_IN == 4'hF);
  // An abort in the same cycle cancels the terminal event and its side effects.
  assign term_ok     = term && !ABORT;
  assign period_inc  = PERIOD + W_REP'(1);
  // REPEAT of zero means run forever, so it never matches.
  assign last_period = (cfg_rep != '0) && (period_inc == cfg_rep);

  assign CNT_D = cfg_load;
  assign BUSY  = (state == S_LOAD) || (state == S_RUN) || (state == S_CLR);

  // State register; MR returns to IDLE from anywhere.
  always_ff @(posedge CP) begin
    if (MR) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort outranks terminal handling in LOAD and RUN.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (START) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ABORT) begin
          state_nxt = S_CLR;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (ABORT) begin
          state_nxt = S_CLR;
        end else if (term && last_period) begin
          state_nxt = S_FIN;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      S_CLR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counter control strobes; MR forces a clear regardless of state.
  always_comb begin
    CNT_MR_N = 1'b1;
    CNT_PE_N = 1'b1;
    CNT_CEP  = 1'b0;
    CNT_CET  = 1'b0;
    if (MR) begin
      CNT_MR_N = 1'b0;
    end else begin
      unique case (state)
        S_LOAD: begin
          CNT_PE_N = 1'b0;
        end
        S_RUN: begin
          CNT_CEP = !HOLD;
          CNT_CET = !HOLD;
          // Load wins over count in the counter, so this gives a zero-gap reload.
          if (term_ok && !last_period && cfg_mode) begin
            CNT_PE_N = 1'b0;
          end
        end
        S_CLR: begin
          CNT_MR_N = 1'b0;
        end
        default: begin
          CNT_MR_N = 1'b1;
        end
      endcase
    end
  end

  // Latch the configuration when a START is accepted in IDLE.
  always_ff @(posedge CP) begin
    if (MR) begin
      cfg_load <= 4'd0;
      cfg_rep  <= '0;
      cfg_mode <= 1'b0;
    end else if ((state == S_IDLE) && START) begin
      cfg_load <= LOAD_VAL;
      cfg_rep  <= REPEAT;
      cfg_mode <= MODE;
    end
  end

  // Period counter; it keeps its value after FIN or CLR until the next START.
  always_ff @(posedge CP) begin
    if (MR) begin
      PERIOD <= '0;
    end else if ((state == S_IDLE) && START) begin
      PERIOD <= '0;
    end else if (term_ok) begin
      PERIOD <= period_inc;
    end
  end

  // Registered pulses; the final tick lands in FIN together with DONE.
  always_ff @(posedge CP) begin
    if (MR) begin
      TICK <= 1'b0;
      DONE <= 1'b0;
    end else begin
      TICK <= term_ok;
      DONE <= term_ok && last_period;
    end
  end

endmodule

// File: tb/tb_hc161_seq_ctrl.sv
// Self-checking bench for hc161_seq_ctrl. It contains a behavioural 4-bit
// counter that closes the loop on Q_IN. A scoreboard compares the
// expected TICK/DONE events, including their cycle, with the events
// actually seen.
module tb_hc161_seq_ctrl;

  localparam int W_REP = 8;

  logic             CP = 1'b0;
  logic             MR = 1'b1;
  logic             START = 1'b0;
  logic             ABORT = 1'b0;
  logic             HOLD = 1'b0;
  logic             MODE = 1'b0;
  logic [3:0]       LOAD_VAL = 4'd0;
  logic [W_REP-1:0] REPEAT = '0;
  logic [3:0]       Q_IN;
  logic             CNT_MR_N, CNT_PE_N, CNT_CEP, CNT_CET;
  logic [3:0]       CNT_D;
  logic             BUSY, TICK, DONE;
  logic [W_REP-1:0] PERIOD;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [31:0]      cyc;
    logic             tick;
    logic             done;
    logic [W_REP-1:0] period;
  } ev_t;

  ev_t exp_q[$];
  ev_t act_q[$];

  logic [3:0] q_model = 4'd0;
  assign Q_IN = q_model;

  hc161_seq_ctrl #(.W_REP(W_REP)) dut (
    .CP(CP), .MR(MR), .START(START), .ABORT(ABORT), .HOLD(HOLD), .MODE(MODE),
    .LOAD_VAL(LOAD_VAL), .REPEAT(REPEAT), .Q_IN(Q_IN),
    .CNT_MR_N(CNT_MR_N), .CNT_PE_N(CNT_PE_N), .CNT_CEP(CNT_CEP), .CNT_CET(CNT_CET),
    .CNT_D(CNT_D), .BUSY(BUSY), .TICK(TICK), .DONE(DONE), .PERIOD(PERIOD)
  );

  always #5 CP = ~CP;

  always @(posedge CP) cyc <= cyc + 1;

  // Counter stage: clear beats load, and load beats count.
  always @(posedge CP) begin
    if (!CNT_MR_N)              q_model <= 4'd0;
    else if (!CNT_PE_N)         q_model <= CNT_D;
    else if (CNT_CEP && CNT_CET) q_model <= q_model + 4'd1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input int c, input logic t, input logic d, input int p);
    ev_t e;
    e.cyc = c;
    e.tick = t;
    e.done = d;
    e.period = p[W_REP-1:0];
    exp_q.push_back(e);
  endtask

  // Advance n cycles, sampling at each falling edge and recording pulses.
  task automatic run_cycles(input int n);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge CP);
      if (TICK || DONE) begin
        e.cyc = cyc;
        e.tick = TICK;
        e.done = DONE;
        e.period = PERIOD;
        act_q.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({CNT_MR_N, CNT_PE_N, CNT_CEP, CNT_CET} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_strobes: got %b, expected 0100", {CNT_MR_N, CNT_PE_N, CNT_CEP, CNT_CET});
    end
    @(negedge CP);
    @(negedge CP);
    checks++;
    if ({BUSY, TICK, DONE} !== 3'b000 || PERIOD !== '0 || CNT_D !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got busy/tick/done=%b period=%0d d=%0d, expected 000/0/0",
               {BUSY, TICK, DONE}, PERIOD, CNT_D);
    end
    checks++;
    if (CNT_MR_N !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_clear: got mr_n=%b, expected 0", CNT_MR_N);
    end
    MR = 1'b0;
    @(negedge CP);
    checks++;
    if (CNT_MR_N !== 1'b1 || BUSY !== 1'b0 || CNT_CEP !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got mr_n=%b busy=%b cep=%b, expected 1 0 0", CNT_MR_N, BUSY, CNT_CEP);
    end
  endtask

  task automatic test_reload();
    int r;
    ev_t e, a;
    LOAD_VAL = 4'd12; REPEAT = 8'd3; MODE = 1'b1; START = 1'b1;
    r = cyc;
    push_exp(r + 6, 1'b1, 1'b0, 1);
    push_exp(r + 10, 1'b1, 1'b0, 2);
    push_exp(r + 14, 1'b1, 1'b1, 3);
    run_cycles(1);
    checks++;
    if (CNT_PE_N !== 1'b0 || CNT_D !== 4'd12 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL reload_load: got pe_n=%b d=%0d busy=%b, expected 0 12 1", CNT_PE_N, CNT_D, BUSY);
    end
    START = 1'b0;
    run_cycles(1);
    checks++;
    if (q_model !== 4'd12 || CNT_CEP !== 1'b1 || CNT_CET !== 1'b1) begin
      errors++;
      $display("FAIL reload_run0: got q=%0d cep=%b cet=%b, expected 12 1 1", q_model, CNT_CEP, CNT_CET);
    end
    run_cycles(3);
    checks++;
    if (q_model !== 4'd15 || CNT_PE_N !== 1'b0) begin
      errors++;
      $display("FAIL reload_pe: got q=%0d pe_n=%b, expected 15 0", q_model, CNT_PE_N);
    end
    run_cycles(10);
    checks++;
    if (BUSY !== 1'b0 || PERIOD !== 8'd3 || q_model !== 4'd0) begin
      errors++;
      $display("FAIL reload_end: got busy=%b period=%0d q=%0d, expected 0 3 0", BUSY, PERIOD, q_model);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) begin
        errors++;
        $display("FAIL reload_event: missing, expected cyc=%0d tick=%b done=%b period=%0d", e.cyc, e.tick, e.done, e.period);
      end else begin
        a = act_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL reload_event: got cyc=%0d tick=%b done=%b period=%0d, expected cyc=%0d tick=%b done=%b period=%0d",
                   a.cyc, a.tick, a.done, a.period, e.cyc, e.tick, e.done, e.period);
        end
      end
    end
    checks++;
    if (act_q.size() != 0) begin
      errors++;
      $display("FAIL reload_extra: got %0d unexpected events, expected 0", act_q.size());
      act_q.delete();
    end
  endtask

  task automatic test_free_wrap();
    int r;
    ev_t e, a;
    LOAD_VAL = 4'd12; REPEAT = 8'd2; MODE = 1'b0; START = 1'b1;
    r = cyc;
    push_exp(r + 6, 1'b1, 1'b0, 1);
    push_exp(r + 22, 1'b1, 1'b1, 2);
    run_cycles(1);
    START = 1'b0;
    run_cycles(4);
    checks++;
    if (q_model !== 4'd15 || CNT_PE_N !== 1'b1) begin
      errors++;
      $display("FAIL wrap_pe: got q=%0d pe_n=%b, expected 15 1", q_model, CNT_PE_N);
    end
    run_cycles(1);
    checks++;
    if (q_model !== 4'd0) begin
      errors++;
      $display("FAIL wrap_zero: got q=%0d, expected 0", q_model);
    end
    run_cycles(17);
    checks++;
    if (BUSY !== 1'b0 || PERIOD !== 8'd2) begin
      errors++;
      $display("FAIL wrap_end: got busy=%b period=%0d, expected 0 2", BUSY, PERIOD);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) begin
        errors++;
        $display("FAIL wrap_event: missing, expected cyc=%0d tick=%b done=%b period=%0d", e.cyc, e.tick, e.done, e.period);
      end else begin
        a = act_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL wrap_event: got cyc=%0d tick=%b done=%b period=%0d, expected cyc=%0d tick=%b done=%b period=%0d",
                   a.cyc, a.tick, a.done, a.period, e.cyc, e.tick, e.done, e.period);
        end
      end
    end
    checks++;
    if (act_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_extra: got %0d unexpected events, expected 0", act_q.size());
      act_q.delete();
    end
  endtask

  task automatic test_hold();
    int r;
    ev_t e, a;
    LOAD_VAL = 4'd12; REPEAT = 8'd2; MODE = 1'b0; START = 1'b1;
    r = cyc;
    push_exp(r + 6, 1'b1, 1'b0, 1);
    push_exp(r + 25, 1'b1, 1'b1, 2);
    run_cycles(1);
    START = 1'b0;
    run_cycles(20);
    checks++;
    if (q_model !== 4'd15) begin
      errors++;
      $display("FAIL hold_pre: got q=%0d, expected 15", q_model);
    end
    HOLD = 1'b1;
    run_cycles(3);
    checks++;
    if (q_model !== 4'd15 || CNT_CEP !== 1'b0 || CNT_CET !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL hold_frozen: got q=%0d cep=%b cet=%b busy=%b, expected 15 0 0 1", q_model, CNT_CEP, CNT_CET, BUSY);
    end
    HOLD = 1'b0;
    run_cycles(2);
    checks++;
    if (BUSY !== 1'b0 || PERIOD !== 8'd2) begin
      errors++;
      $display("FAIL hold_end: got busy=%b period=%0d, expected 0 2", BUSY, PERIOD);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) begin
        errors++;
        $display("FAIL hold_event: missing, expected cyc=%0d tick=%b done=%b period=%0d", e.cyc, e.tick, e.done, e.period);
      end else begin
        a = act_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL hold_event: got cyc=%0d tick=%b done=%b period=%0d, expected cyc=%0d tick=%b done=%b period=%0d",
                   a.cyc, a.tick, a.done, a.period, e.cyc, e.tick, e.done, e.period);
        end
      end
    end
    checks++;
    if (act_q.size() != 0) begin
      errors++;
      $display("FAIL hold_extra: got %0d unexpected events, expected 0", act_q.size());
      act_q.delete();
    end
  endtask

  task automatic test_abort();
    int r;
    ev_t e, a;
    LOAD_VAL = 4'd12; REPEAT = 8'd3; MODE = 1'b1; START = 1'b1;
    r = cyc;
    push_exp(r + 6, 1'b1, 1'b0, 1);
    run_cycles(1);
    START = 1'b0;
    run_cycles(8);
    checks++;
    if (q_model !== 4'd15) begin
      errors++;
      $display("FAIL abort_pre: got q=%0d, expected 15", q_model);
    end
    ABORT = 1'b1;
    #1;
    checks++;
    if (CNT_PE_N !== 1'b1) begin
      errors++;
      $display("FAIL abort_no_reload: got pe_n=%b, expected 1", CNT_PE_N);
    end
    run_cycles(1);
    checks++;
    if (CNT_MR_N !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL abort_clr: got mr_n=%b busy=%b, expected 0 1", CNT_MR_N, BUSY);
    end
    ABORT = 1'b0;
    run_cycles(1);
    checks++;
    if (CNT_MR_N !== 1'b1 || BUSY !== 1'b0 || PERIOD !== 8'd1 || q_model !== 4'd0) begin
      errors++;
      $display("FAIL abort_idle: got mr_n=%b busy=%b period=%0d q=%0d, expected 1 0 1 0", CNT_MR_N, BUSY, PERIOD, q_model);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) begin
        errors++;
        $display("FAIL abort_event: missing, expected cyc=%0d tick=%b done=%b period=%0d", e.cyc, e.tick, e.done, e.period);
      end else begin
        a = act_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL abort_event: got cyc=%0d tick=%b done=%b period=%0d, expected cyc=%0d tick=%b done=%b period=%0d",
                   a.cyc, a.tick, a.done, a.period, e.cyc, e.tick, e.done, e.period);
        end
      end
    end
    checks++;
    if (act_q.size() != 0) begin
      errors++;
      $display("FAIL abort_extra: got %0d unexpected events, expected 0", act_q.size());
      act_q.delete();
    end
  endtask

  task automatic test_endless();
    int r;
    ev_t e, a;
    LOAD_VAL = 4'd15; REPEAT = 8'd0; MODE = 1'b1; START = 1'b1; ABORT = 1'b1;
    r = cyc;
    for (int k = 1; k <= 260; k++) push_exp(r + 2 + k, 1'b1, 1'b0, k % 256);
    run_cycles(1);
    checks++;
    if (BUSY !== 1'b1 || CNT_PE_N !== 1'b0 || CNT_D !== 4'd15) begin
      errors++;
      $display("FAIL endless_start: got busy=%b pe_n=%b d=%0d, expected 1 0 15", BUSY, CNT_PE_N, CNT_D);
    end
    START = 1'b0; ABORT = 1'b0;
    run_cycles(100);
    START = 1'b1;
    run_cycles(5);
    START = 1'b0;
    run_cycles(156);
    checks++;
    if (PERIOD !== 8'd4 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL endless_period: got period=%0d busy=%b, expected 4 1", PERIOD, BUSY);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) begin
        errors++;
        $display("FAIL endless_event: missing, expected cyc=%0d tick=%b done=%b period=%0d", e.cyc, e.tick, e.done, e.period);
      end else begin
        a = act_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL endless_event: got cyc=%0d tick=%b done=%b period=%0d, expected cyc=%0d tick=%b done=%b period=%0d",
                   a.cyc, a.tick, a.done, a.period, e.cyc, e.tick, e.done, e.period);
        end
      end
    end
    checks++;
    if (act_q.size() != 0) begin
      errors++;
      $display("FAIL endless_extra: got %0d unexpected events, expected 0", act_q.size());
      act_q.delete();
    end
    MR = 1'b1;
    #1;
    checks++;
    if (CNT_MR_N !== 1'b0 || CNT_CEP !== 1'b0 || CNT_PE_N !== 1'b1) begin
      errors++;
      $display("FAIL endless_mr_strobes: got mr_n=%b cep=%b pe_n=%b, expected 0 0 1", CNT_MR_N, CNT_CEP, CNT_PE_N);
    end
    @(negedge CP);
    checks++;
    if (BUSY !== 1'b0 || TICK !== 1'b0 || DONE !== 1'b0 || PERIOD !== '0) begin
      errors++;
      $display("FAIL endless_mr_reset: got busy=%b tick=%b done=%b period=%0d, expected 0 0 0 0", BUSY, TICK, DONE, PERIOD);
    end
    MR = 1'b0;
    @(negedge CP);
    checks++;
    if (CNT_MR_N !== 1'b1 || BUSY !== 1'b0 || TICK !== 1'b0) begin
      errors++;
      $display("FAIL endless_post_mr: got mr_n=%b busy=%b tick=%b, expected 1 0 0", CNT_MR_N, BUSY, TICK);
    end
  endtask

  initial begin
    test_reset();
    test_reload();
    test_free_wrap();
    test_hold();
    test_abort();
    test_endless();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
